dual_issue_ibuf: RTL and testbench
==================================

# dual_issue_ibuf

Instruction buffer and dequeue scheduler between the IF stage and the dual-issue launch stage. Accepts up to two fetched instructions per cycle, presents the two oldest as line1/line2 to launch, and retires 0, 1 or 2 entries per cycle according to the launch arbitration result (dual, single, or stall). This decouples fetch from launch stalls, so a single-issue cycle no longer back-pressures the whole fetch pair. Branch and exception flushes empty the buffer.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥4.
- ENTRY_W, 64, per-instruction payload {pc[63:32], inst[31:0]}.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- excep_flush_i  in  1  exception flush; discards all entries.
- branch_flush_i  in  1  branch-mispredict flush from launch; discards all entries.
- line1_in_valid_i  in  1  fetch slot 1 valid.
- line2_in_valid_i  in  1  fetch slot 2 valid.
- in_bus_i  in  2*ENTRY_W  {slot2, slot1}; slot1 is older.
- allowin_o  out  1  free entries ≥ 2.
- line1_out_valid_o  out  1  count ≥ 1.
- line2_out_valid_o  out  1  count ≥ 2.
- out_bus_o  out  2*ENTRY_W  {head+1, head}; a slot is zero when its valid is low.
- deq_num_i  in  2  entries consumed by launch this cycle (0/1/2; 3 treated as 2).
- count_o  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: circular array of DEPTH entries; rd_ptr, wr_ptr (log2 DEPTH bits, natural wrap); count.
- Enqueue is accepted only when allowin_o=1. Valid slots are compacted: slot2-only is written as one entry at wr_ptr. enq_num = line1_in_valid_i + line2_in_valid_i when accepted, else 0.
- Dequeue: deq_eff = min(deq_num_i clamped to 2, count). rd_ptr += deq_eff.
- Update: count_next = count + enq_num − deq_eff; wr_ptr += enq_num.
- Flush: excep_flush_i or branch_flush_i forces rd_ptr=wr_ptr=0 and count=0 on the next edge. Enqueue and dequeue in that cycle are ignored; array contents are not cleared.
- Outputs are combinational from registered state only; there is no path from in_bus_i to out_bus_o in the same cycle.
- Reset: pointers=0, count=0, so allowin_o=1, both out valids=0, out_bus_o=0, count_o=0.

## Timing
- Enqueue-to-visible latency: 1 cycle. An entry written at edge N is presented on out_bus_o after edge N.
- Back-to-back enqueue and dequeue are allowed in the same cycle. allowin_o is evaluated from the pre-edge count, so a simultaneous dequeue does not raise it in that cycle.
- Full: count ≥ DEPTH−1 forces allowin_o=0, and no write occurs. Empty: deq_num_i is ignored.
- Wrap: a write of two entries at wr_ptr=DEPTH−1 places slot1 at DEPTH−1 and slot2 at index 0. A read of two entries at rd_ptr=DEPTH−1 presents head+1 from index 0.
- Flush coinciding with a full buffer, a wrap, or enqueue: the flush wins and count is 0 next cycle.
- Reset asserted mid-operation clears state immediately (asynchronously). On release, operation resumes with the first edge.

## Structure
- Shared package: ENTRY_W default, deq-count encodings (DEQ_NONE=0, DEQ_ONE=1, DEQ_TWO=2), and the flush-OR helper, which launch also uses.
- One sub-module, ibuf_regfile: 2-write/2-read register array with modulo-DEPTH addressing for index and index+1. No reset on data.
- Top: pointer and count logic, clamp, compaction, and output masking.

## Test plan
- Reset then idle: out valids 0, out_bus_o=0, count_o=0, allowin_o=1.
- Enqueue pairs (pc 0x1c000000/04, 08/0c) with deq_num_i=0: count 4 after two cycles, out_bus_o={0x…04 pair, 0x…00 pair}, line2_out_valid_o=1.
- deq_num_i=1 while enqueuing slot2-only pc 0x10: count 4→4, head becomes pc 0x04, entry pc 0x10 lands directly after 0x0c.
- Fill to count 7 with DEPTH=8: allowin_o=0, further input is dropped. deq_num_i=2 then gives count 5 and allowin_o=1 the next cycle.
- Wrap: with rd_ptr=wr_ptr=7, enqueue pair A,B. Next cycle out_bus_o={B from index 0, A from index 7}.
- Flush together with enqueue and deq_num_i=2 at count 5: next cycle count 0, out valids 0. The following enqueue appears at index 0.

Source files
------------

// File: rtl/dual_issue_ibuf_pkg.sv
// Shared types and constants for the dual-issue instruction buffer and launch stage.
package dual_issue_ibuf_pkg;

  localparam int unsigned IBUF_ENTRY_W = 64;
  localparam int unsigned IBUF_DEPTH   = 8;

  // Encodings of the number of entries launch consumes in one cycle.
  localparam logic [1:0] DEQ_NONE = 2'd0;
  localparam logic [1:0] DEQ_ONE  = 2'd1;
  localparam logic [1:0] DEQ_TWO  = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ibuf_entry_t;

  // Any pipeline flush empties the buffer; launch uses the same combine.
  function automatic logic flush_any(input logic excep_flush, input logic branch_flush);
    return excep_flush | branch_flush;
  endfunction

endpackage

// File: rtl/dual_issue_ibuf_if.sv
// Fetch/launch-facing bundle of the instruction buffer.
interface dual_issue_ibuf_if
  import dual_issue_ibuf_pkg::*;
#(
  parameter int unsigned DEPTH   = IBUF_DEPTH,
  parameter int unsigned ENTRY_W = IBUF_ENTRY_W
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                 excep_flush_i;
  logic                 branch_flush_i;
  logic                 line1_in_valid_i;
  logic                 line2_in_valid_i;
  logic [2*ENTRY_W-1:0] in_bus_i;
  logic                 allowin_o;
  logic                 line1_out_valid_o;
  logic                 line2_out_valid_o;
  logic [2*ENTRY_W-1:0] out_bus_o;
  logic [1:0]           deq_num_i;
  logic [CW-1:0]        count_o;

  modport master (
    output excep_flush_i, branch_flush_i, line1_in_valid_i, line2_in_valid_i,
           in_bus_i, deq_num_i,
    input  allowin_o, line1_out_valid_o, line2_out_valid_o, out_bus_o, count_o
  );

  modport slave (
    input  excep_flush_i, branch_flush_i, line1_in_valid_i, line2_in_valid_i,
           in_bus_i, deq_num_i,
    output allowin_o, line1_out_valid_o, line2_out_valid_o, out_bus_o, count_o
  );

endinterface

// File: rtl/dual_issue_ibuf_regfile.sv
// 2-write/2-read entry array; second port of each pair addresses index+1 modulo DEPTH.
module ibuf_regfile #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ENTRY_W = 64
) (
  input  logic                       clk,
  input  logic                       we0_i,
  input  logic                       we1_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [ENTRY_W-1:0]         wdata0_i,
  input  logic [ENTRY_W-1:0]         wdata1_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [ENTRY_W-1:0]         rdata0_c,
  output logic [ENTRY_W-1:0]         rdata1_c
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      waddr_p1;
  logic [AW-1:0]      raddr_p1;

  // Power-of-two depth lets the +1 wrap naturally in AW bits.
  always_comb begin
    waddr_p1 = AW'(waddr_i + AW'(1));
    raddr_p1 = AW'(raddr_i + AW'(1));
    rdata0_c = mem_q[raddr_i];
    rdata1_c = mem_q[raddr_p1];
  end

  // Payload storage carries no reset; validity lives in the pointer/count state.
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr_i]  <= wdata0_i;
    if (we1_i) mem_q[waddr_p1] <= wdata1_i;
  end

endmodule

// File: rtl/dual_issue_ibuf.sv
// Instruction buffer between fetch and dual-issue launch: compacting enqueue of up
// to two entries, 0/1/2 dequeue per cycle, flush to empty.
module dual_issue_ibuf
  import dual_issue_ibuf_pkg::*;
#(
  parameter int unsigned DEPTH   = IBUF_DEPTH,
  parameter int unsigned ENTRY_W = IBUF_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  dual_issue_ibuf_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic               flush;
  logic               allowin_c;
  logic [1:0]         enq_num;
  logic [1:0]         deq_clamp;
  logic [1:0]         deq_eff;
  logic               we0, we1;
  logic [ENTRY_W-1:0] slot1, slot2;
  logic [ENTRY_W-1:0] wdata0;
  logic [ENTRY_W-1:0] rdata0, rdata1;

  always_comb begin
    flush     = flush_any(bus.excep_flush_i, bus.branch_flush_i);
    allowin_c = (count_q <= CW'(DEPTH - 2));
    slot1     = bus.in_bus_i[ENTRY_W-1:0];
    slot2     = bus.in_bus_i[2*ENTRY_W-1:ENTRY_W];

    enq_num = 2'd0;
    if (allowin_c && !flush)
      enq_num = {1'b0, bus.line1_in_valid_i} + {1'b0, bus.line2_in_valid_i};

    // Compaction: a lone slot2 goes to wr_ptr, not wr_ptr+1.
    we0    = (enq_num != 2'd0);
    we1    = (enq_num == 2'd2);
    wdata0 = bus.line1_in_valid_i ? slot1 : slot2;

    deq_clamp = (bus.deq_num_i == 2'd3) ? DEQ_TWO : bus.deq_num_i;
    deq_eff   = deq_clamp;
    if (count_q == '0)
      deq_eff = DEQ_NONE;
    else if (count_q == CW'(1) && deq_clamp == DEQ_TWO)
      deq_eff = DEQ_ONE;

    rd_ptr_d = AW'(rd_ptr_q + AW'(deq_eff));
    wr_ptr_d = AW'(wr_ptr_q + AW'(enq_num));
    count_d  = CW'(count_q + CW'(enq_num) - CW'(deq_eff));
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  ibuf_regfile #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_regfile (
    .clk      (clk),
    .we0_i    (we0),
    .we1_i    (we1),
    .waddr_i  (wr_ptr_q),
    .wdata0_i (wdata0),
    .wdata1_i (slot2),
    .raddr_i  (rd_ptr_q),
    .rdata0_c (rdata0),
    .rdata1_c (rdata1)
  );

  // Outputs depend on registered state only; invalid slots read as zero.
  always_comb begin
    bus.allowin_o         = allowin_c;
    bus.line1_out_valid_o = (count_q != '0);
    bus.line2_out_valid_o = (count_q >= CW'(2));
    bus.out_bus_o         = '0;
    if (bus.line1_out_valid_o) bus.out_bus_o[ENTRY_W-1:0]         = rdata0;
    if (bus.line2_out_valid_o) bus.out_bus_o[2*ENTRY_W-1:ENTRY_W] = rdata1;
    bus.count_o           = count_q;
  end

endmodule

// File: tb/tb_dual_issue_ibuf.sv
// Scoreboard bench for dual_issue_ibuf: a queue model tracks buffered entries.
module tb_dual_issue_ibuf;
  import dual_issue_ibuf_pkg::*;

  localparam int DEPTH = 8;
  localparam int EW    = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_issue_ibuf_if #(.DEPTH(DEPTH), .ENTRY_W(EW)) bus ();
  dual_issue_ibuf #(.DEPTH(DEPTH), .ENTRY_W(EW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [EW-1:0] mq[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [EW-1:0] ent(input logic [31:0] pc);
    ibuf_entry_t e;
    e.pc   = pc;
    e.inst = pc ^ 32'h0000_0013;
    return e;
  endfunction

  function automatic logic [2*EW-1:0] exp_bus();
    logic [2*EW-1:0] r;
    r = '0;
    if (mq.size() > 0) r[EW-1:0]    = mq[0];
    if (mq.size() > 1) r[2*EW-1:EW] = mq[1];
    return r;
  endfunction

  task automatic idle_inputs();
    bus.excep_flush_i    = 1'b0;
    bus.branch_flush_i   = 1'b0;
    bus.line1_in_valid_i = 1'b0;
    bus.line2_in_valid_i = 1'b0;
    bus.in_bus_i         = '0;
    bus.deq_num_i        = 2'd0;
  endtask

  // Drive one cycle of stimulus and advance the model with the pre-edge state.
  task automatic cycle(input logic v1, input logic v2, input logic [31:0] pc1,
                       input logic [31:0] pc2, input logic [1:0] deq,
                       input logic fe, input logic fb);
    int  d;
    bit  allow;
    bus.line1_in_valid_i = v1;
    bus.line2_in_valid_i = v2;
    bus.in_bus_i         = {ent(pc2), ent(pc1)};
    bus.deq_num_i        = deq;
    bus.excep_flush_i    = fe;
    bus.branch_flush_i   = fb;
    allow = (mq.size() <= DEPTH - 2);
    if (fe || fb) begin
      mq.delete();
    end else begin
      d = (deq == 2'd3) ? 2 : int'(deq);
      if (d > mq.size()) d = mq.size();
      repeat (d) void'(mq.pop_front());
      if (allow) begin
        if (v1) mq.push_back(ent(pc1));
        if (v2) mq.push_back(ent(pc2));
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    n_vec++; if (bus.line1_out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_l1v got %b want 0", bus.line1_out_valid_o); end
    n_vec++; if (bus.line2_out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_l2v got %b want 0", bus.line2_out_valid_o); end
    n_vec++; if (bus.out_bus_o !== '0) begin n_err++; $display("FAIL reset_bus got %h want 0", bus.out_bus_o); end
    n_vec++; if (bus.count_o !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
    n_vec++; if (bus.allowin_o !== 1'b1) begin n_err++; $display("FAIL reset_allowin got %b want 1", bus.allowin_o); end
  endtask

  task automatic test_enqueue_pairs();
    cycle(1, 1, 32'h1c00_0000, 32'h1c00_0004, 2'd0, 0, 0);
    n_vec++; if (bus.count_o !== 4'd2) begin n_err++; $display("FAIL enq_count1 got %0d want 2", bus.count_o); end
    cycle(1, 1, 32'h1c00_0008, 32'h1c00_000c, 2'd0, 0, 0);
    n_vec++; if (bus.count_o !== 4'd4) begin n_err++; $display("FAIL enq_count2 got %0d want 4", bus.count_o); end
    n_vec++; if (bus.out_bus_o !== {ent(32'h1c00_0004), ent(32'h1c00_0000)}) begin n_err++; $display("FAIL enq_bus got %h want %h", bus.out_bus_o, {ent(32'h1c00_0004), ent(32'h1c00_0000)}); end
    n_vec++; if (bus.line2_out_valid_o !== 1'b1) begin n_err++; $display("FAIL enq_l2v got %b want 1", bus.line2_out_valid_o); end
  endtask

  task automatic test_deq_single();
    cycle(0, 1, 32'h0, 32'h1c00_0010, 2'd1, 0, 0);
    n_vec++; if (bus.count_o !== 4'd4) begin n_err++; $display("FAIL deq1_count got %0d want 4", bus.count_o); end
    n_vec++; if (bus.out_bus_o !== {ent(32'h1c00_0008), ent(32'h1c00_0004)}) begin n_err++; $display("FAIL deq1_bus got %h want %h", bus.out_bus_o, {ent(32'h1c00_0008), ent(32'h1c00_0004)}); end
  endtask

  task automatic test_full();
    cycle(1, 1, 32'h1c00_0020, 32'h1c00_0024, 2'd0, 0, 0);
    n_vec++; if (bus.allowin_o !== 1'b1) begin n_err++; $display("FAIL full_allow6 got %b want 1", bus.allowin_o); end
    cycle(1, 0, 32'h1c00_0028, 32'h0, 2'd0, 0, 0);
    n_vec++; if (bus.count_o !== 4'd7) begin n_err++; $display("FAIL full_count7 got %0d want 7", bus.count_o); end
    n_vec++; if (bus.allowin_o !== 1'b0) begin n_err++; $display("FAIL full_allow7 got %b want 0", bus.allowin_o); end
    cycle(1, 1, 32'h1c00_0030, 32'h1c00_0034, 2'd0, 0, 0);
    n_vec++; if (bus.count_o !== 4'd7) begin n_err++; $display("FAIL full_drop got %0d want 7", bus.count_o); end
    cycle(0, 0, 32'h0, 32'h0, 2'd2, 0, 0);
    n_vec++; if (bus.count_o !== 4'd5) begin n_err++; $display("FAIL full_deq2 got %0d want 5", bus.count_o); end
    n_vec++; if (bus.allowin_o !== 1'b1) begin n_err++; $display("FAIL full_reallow got %b want 1", bus.allowin_o); end
    n_vec++; if (bus.out_bus_o !== {ent(32'h1c00_0010), ent(32'h1c00_000c)}) begin n_err++; $display("FAIL full_order got %h want %h", bus.out_bus_o, {ent(32'h1c00_0010), ent(32'h1c00_000c)}); end
    cycle(0, 0, 32'h0, 32'h0, 2'd2, 0, 0);
    n_vec++; if (bus.out_bus_o !== {ent(32'h1c00_0024), ent(32'h1c00_0020)}) begin n_err++; $display("FAIL drain_bus got %h want %h", bus.out_bus_o, {ent(32'h1c00_0024), ent(32'h1c00_0020)}); end
    cycle(0, 0, 32'h0, 32'h0, 2'd2, 0, 0);
    n_vec++; if (bus.out_bus_o !== {64'h0, ent(32'h1c00_0028)}) begin n_err++; $display("FAIL drain_last got %h want %h", bus.out_bus_o, {64'h0, ent(32'h1c00_0028)}); end
    cycle(0, 0, 32'h0, 32'h0, 2'd2, 0, 0);
    n_vec++; if (bus.count_o !== 4'd0) begin n_err++; $display("FAIL drain_clamp got %0d want 0", bus.count_o); end
  endtask

  // Pointers end at 0 here; walk them to 7 with single enqueue+dequeue cycles.
  task automatic test_wrap();
    cycle(1, 0, 32'h1c00_0040, 32'h0, 2'd0, 0, 0);
    for (int i = 1; i < 7; i++) cycle(1, 0, 32'h1c00_0040 + 32'(4 * i), 32'h0, 2'd1, 0, 0);
    cycle(0, 0, 32'h0, 32'h0, 2'd1, 0, 0);
    cycle(0, 0, 32'h0, 32'h0, 2'd3, 0, 0);
    n_vec++; if (bus.count_o !== 4'd0) begin n_err++; $display("FAIL wrap_empty got %0d want 0", bus.count_o); end
    cycle(1, 1, 32'h1c00_0080, 32'h1c00_0084, 2'd0, 0, 0);
    n_vec++; if (bus.out_bus_o !== {ent(32'h1c00_0084), ent(32'h1c00_0080)}) begin n_err++; $display("FAIL wrap_bus got %h want %h", bus.out_bus_o, {ent(32'h1c00_0084), ent(32'h1c00_0080)}); end
    cycle(1, 1, 32'h1c00_0088, 32'h1c00_008c, 2'd3, 0, 0);
    n_vec++; if (bus.out_bus_o !== {ent(32'h1c00_008c), ent(32'h1c00_0088)}) begin n_err++; $display("FAIL wrap_deq3 got %h want %h", bus.out_bus_o, {ent(32'h1c00_008c), ent(32'h1c00_0088)}); end
  endtask

  task automatic test_flush();
    cycle(1, 1, 32'h1c00_00a0, 32'h1c00_00a4, 2'd0, 0, 0);
    cycle(1, 0, 32'h1c00_00a8, 32'h0, 2'd0, 0, 0);
    n_vec++; if (bus.count_o !== 4'd5) begin n_err++; $display("FAIL flush_pre got %0d want 5", bus.count_o); end
    cycle(1, 1, 32'h1c00_00b0, 32'h1c00_00b4, 2'd2, 1, 0);
    n_vec++; if (bus.count_o !== 4'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", bus.count_o); end
    n_vec++; if (bus.line1_out_valid_o !== 1'b0 || bus.out_bus_o !== '0) begin n_err++; $display("FAIL flush_out got v=%b bus=%h want v=0 bus=0", bus.line1_out_valid_o, bus.out_bus_o); end
    cycle(0, 1, 32'h0, 32'h1c00_00c0, 2'd0, 0, 0);
    n_vec++; if (bus.out_bus_o !== {64'h0, ent(32'h1c00_00c0)}) begin n_err++; $display("FAIL flush_after got %h want %h", bus.out_bus_o, {64'h0, ent(32'h1c00_00c0)}); end
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h1c00_0100 + 32'(8 * i), 32'h1c00_0104 + 32'(8 * i), 2'd0, 0, 0);
    n_vec++; if (bus.count_o !== 4'd7) begin n_err++; $display("FAIL flush_full got %0d want 7", bus.count_o); end
    cycle(1, 1, 32'h1c00_0200, 32'h1c00_0204, 2'd1, 0, 1);
    n_vec++; if (bus.count_o !== 4'd0 || bus.allowin_o !== 1'b1) begin n_err++; $display("FAIL bflush got count=%0d allow=%b want count=0 allow=1", bus.count_o, bus.allowin_o); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 1, 32'h1c00_0300, 32'h1c00_0304, 2'd0, 0, 0);
    rst_n = 1'b0;
    mq.delete();
    #1;
    n_vec++; if (bus.count_o !== 4'd0 || bus.line1_out_valid_o !== 1'b0) begin n_err++; $display("FAIL async_rst got count=%0d v=%b want 0 0", bus.count_o, bus.line1_out_valid_o); end
    #2;
    rst_n = 1'b1;
    cycle(1, 0, 32'h1c00_0310, 32'h0, 2'd0, 0, 0);
    n_vec++; if (bus.out_bus_o !== {64'h0, ent(32'h1c00_0310)}) begin n_err++; $display("FAIL rst_resume got %h want %h", bus.out_bus_o, {64'h0, ent(32'h1c00_0310)}); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h1c01_0000;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc, pc + 32'd4,
            2'($urandom_range(0, 3)), ($urandom_range(0, 40) == 0), ($urandom_range(0, 40) == 0));
      pc = pc + 32'd8;
      n_vec++;
      if (bus.count_o !== 4'(mq.size()) || bus.out_bus_o !== exp_bus() ||
          bus.allowin_o !== (mq.size() <= DEPTH - 2) ||
          bus.line1_out_valid_o !== (mq.size() >= 1) || bus.line2_out_valid_o !== (mq.size() >= 2)) begin
        n_err++;
        $display("FAIL rand[%0d] got count=%0d allow=%b bus=%h want count=%0d bus=%h", i,
                 bus.count_o, bus.allowin_o, bus.out_bus_o, mq.size(), exp_bus());
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_enqueue_pairs();
    test_deq_single();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
